// File: rtl/lbl_blk_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | lbl_blk_pkg : shared types and helpers for labelled_block_counter_bank  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package lbl_blk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // A single channel still needs a one-bit index port.
  function automatic int idx_w(input int ch);
    return (ch <= 1) ? 1 : $clog2(ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lbl_blk_scanner.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | lbl_blk_scanner : walks every channel slice, streams it, sums the bank  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module lbl_blk_scanner
  import lbl_blk_pkg::*;
#(
  parameter int CH    = 4,
  parameter int W     = 8,
  parameter int IDX_W = idx_w(CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scan_start,
  input  logic [CH*W-1:0]      bus,
  output logic                 scan_busy,
  output logic                 scan_valid,
  output logic [IDX_W-1:0]     scan_ch,
  output logic [W-1:0]         scan_val,
  output logic                 scan_done,
  output logic [W+IDX_W-1:0]   scan_sum
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH - 1);

  scan_state_t            state;
  logic [IDX_W-1:0]       idx;
  logic [W+IDX_W-1:0]     acc;
  logic [W-1:0]           cur_val;

  // Slice is taken from the bus before this edge's counter update.
  assign cur_val = bus[W*int'(idx) +: W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      scan_busy  <= 1'b0;
      scan_valid <= 1'b0;
      scan_ch    <= '0;
      scan_val   <= '0;
      scan_done  <= 1'b0;
      scan_sum   <= '0;
    end else begin
      scan_valid <= 1'b0;
      scan_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (scan_start) begin
            state     <= SCAN;
            idx       <= '0;
            acc       <= '0;
            scan_busy <= 1'b1;
          end
        end
        SCAN: begin
          scan_ch    <= idx;
          scan_val   <= cur_val;
          scan_valid <= 1'b1;
          acc        <= acc + (W+IDX_W)'(cur_val);
          if (idx == LAST_IDX) begin
            state     <= DONE;
            scan_busy <= 1'b0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          scan_sum  <= acc;
          scan_done <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          scan_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/labelled_block_counter_bank.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | labelled_block_counter_bank : CH loadable counters in labelled scopes   |
// | plus a scanner; macro LBL_BLOCK_SATURATE_EN selects saturating counts.  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module labelled_block_counter_bank
  import lbl_blk_pkg::*;
#(
  parameter  int CH    = 4,
  parameter  int W     = 8,
  localparam int IDX_W = idx_w(CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CH-1:0]        en,
  input  logic                 load,
  input  logic [IDX_W-1:0]     load_ch,
  input  logic [W-1:0]         load_val,
  input  logic                 scan_start,
  output logic                 scan_busy,
  output logic                 scan_valid,
  output logic [IDX_W-1:0]     scan_ch,
  output logic [W-1:0]         scan_val,
  output logic                 scan_done,
  output logic [W+IDX_W-1:0]   scan_sum,
  output logic [W-1:0]         ch0_val
);

  logic [CH*W-1:0] bus;

  for (genvar i = 0; i < CH; i++) begin : gen_ch
    logic [W-1:0] cnt;

    // load_ch values at or beyond CH never match any i, so they are ignored.
    always @(posedge clk) begin : upd
      reg [W-1:0] nxt;
`ifdef LBL_BLOCK_SATURATE_EN
      reg         sat;
`endif
      if (!rst_n) begin
        nxt = '0;
      end else if (load && (int'(load_ch) == i)) begin
        nxt = load_val;
      end else if (en[i]) begin
`ifdef LBL_BLOCK_SATURATE_EN
        nxt = (cnt == {W{1'b1}}) ? cnt : cnt + W'(1);
`else
        nxt = cnt + W'(1);
`endif
      end else begin
        nxt = cnt;
      end
`ifdef LBL_BLOCK_SATURATE_EN
      sat <= rst_n && en[i] && (cnt == {W{1'b1}});
`endif
      cnt <= nxt;
    end : upd

    assign bus[i*W +: W] = cnt;
  end : gen_ch

  assign ch0_val = gen_ch[0].cnt;

  lbl_blk_scanner #(
    .CH    (CH),
    .W     (W),
    .IDX_W (IDX_W)
  ) u_scanner (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_start (scan_start),
    .bus        (bus),
    .scan_busy  (scan_busy),
    .scan_valid (scan_valid),
    .scan_ch    (scan_ch),
    .scan_val   (scan_val),
    .scan_done  (scan_done),
    .scan_sum   (scan_sum)
  );

endmodule
`default_nettype wire

// File: tb/tb_labelled_block_counter_bank.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_labelled_block_counter_bank : directed + random bench with a         |
// | timeline-based reference model of counters and scan events. Rev 1.0     |
// +-------------------------------------------------------------------------+
module tb_labelled_block_counter_bank;

  localparam int CH    = 4;
  localparam int W     = 8;
  localparam int IDX_W = 2;
  localparam int MAXV  = (1 << W) - 1;

  logic              clk        = 1'b0;
  logic              rst_n      = 1'b0;
  logic [CH-1:0]     en         = '0;
  logic              load       = 1'b0;
  logic [IDX_W-1:0]  load_ch    = '0;
  logic [W-1:0]      load_val   = '0;
  logic              scan_start = 1'b0;
  logic              scan_busy, scan_valid, scan_done;
  logic [IDX_W-1:0]  scan_ch;
  logic [W-1:0]      scan_val, ch0_val;
  logic [W+IDX_W-1:0] scan_sum;

  // Second instance with CH=5 so load_ch can address non-existent channels.
  logic [4:0]        en5        = '0;
  logic              load5      = 1'b0;
  logic [2:0]        load_ch5   = '0;
  logic [W-1:0]      load_val5  = '0;
  logic              start5     = 1'b0;
  logic              busy5, valid5, done5;
  logic [2:0]        sch5;
  logic [W-1:0]      sval5, c0v5;
  logic [W+2:0]      sum5;

  always #5 clk = ~clk;

  labelled_block_counter_bank #(.CH(CH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_ch(load_ch),
    .load_val(load_val), .scan_start(scan_start), .scan_busy(scan_busy),
    .scan_valid(scan_valid), .scan_ch(scan_ch), .scan_val(scan_val),
    .scan_done(scan_done), .scan_sum(scan_sum), .ch0_val(ch0_val)
  );

  labelled_block_counter_bank #(.CH(5), .W(W)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en5), .load(load5), .load_ch(load_ch5),
    .load_val(load_val5), .scan_start(start5), .scan_busy(busy5),
    .scan_valid(valid5), .scan_ch(sch5), .scan_val(sval5),
    .scan_done(done5), .scan_sum(sum5), .ch0_val(c0v5)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_cnt[CH];
  int cyc    = 0;
  int base   = -1;   // edge number at which the current/last scan was accepted
  int m_acc  = 0;
  int e_valid = 0, e_ch = 0, e_val = 0, e_done = 0, e_sum = 0, e_busy = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bump(input int v);
`ifdef LBL_BLOCK_SATURATE_EN
    return (v == MAXV) ? MAXV : v + 1;
`else
    return (v + 1) % (MAXV + 1);
`endif
  endfunction

  // One clock: update model at the rising edge, compare at the falling edge.
  task automatic tick();
    int pre[CH];
    int k;
    logic [W-1:0] obs[CH];
    @(posedge clk);
    pre = m_cnt;
    if (!rst_n) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      base = -1; m_acc = 0;
      e_valid = 0; e_ch = 0; e_val = 0; e_done = 0; e_sum = 0; e_busy = 0;
    end else begin
      e_valid = 0;
      e_done  = 0;
      if ((base < 0 || cyc >= base + CH + 2) && scan_start) begin
        base  = cyc;
        m_acc = 0;
      end else if (base >= 0) begin
        k = cyc - base - 1;
        if (k >= 0 && k < CH) begin
          e_valid = 1; e_ch = k; e_val = pre[k];
          m_acc += pre[k];
        end else if (k == CH) begin
          e_done = 1; e_sum = m_acc;
        end
      end
      e_busy = (base >= 0 && cyc >= base && cyc <= base + CH - 1) ? 1 : 0;
      for (int i = 0; i < CH; i++) begin
        if (load && int'(load_ch) == i) m_cnt[i] = int'(load_val);
        else if (en[i])                m_cnt[i] = bump(m_cnt[i]);
      end
    end
    cyc++;
    @(negedge clk);
    obs[0] = dut.gen_ch[0].cnt;
    obs[1] = dut.gen_ch[1].cnt;
    obs[2] = dut.gen_ch[2].cnt;
    obs[3] = dut.gen_ch[3].cnt;
    for (int i = 0; i < CH; i++) check($sformatf("cnt%0d", i), 32'(obs[i]), 32'(m_cnt[i]));
    check("ch0_val",    32'(ch0_val),    32'(m_cnt[0]));
    check("scan_busy",  32'(scan_busy),  32'(e_busy));
    check("scan_valid", 32'(scan_valid), 32'(e_valid));
    check("scan_ch",    32'(scan_ch),    32'(e_ch));
    check("scan_val",   32'(scan_val),   32'(e_val));
    check("scan_done",  32'(scan_done),  32'(e_done));
    check("scan_sum",   32'(scan_sum),   32'(e_sum));
  endtask

  task automatic do_load(input int ch, input int val);
    load = 1'b1; load_ch = IDX_W'(ch); load_val = W'(val);
    tick();
    load = 1'b0;
  endtask

  initial begin
    int n, dones, t1, t2, last_ch3;
    logic seen;
    foreach (m_cnt[i]) m_cnt[i] = 0;

    // Reset with all enables high
    rst_n = 1'b0; en = '1;
    repeat (3) tick();
    check("rst_ch0_val", 32'(ch0_val), 32'd0);
    check("rst_busy",    32'(scan_busy), 32'd0);
    check("rst_sum",     32'(scan_sum),  32'd0);
    rst_n = 1'b1; en = '0;

    // Wrap / saturate on channel 2
    do_load(2, 'hFE);
    en = 4'b0100;
    tick();
    check("ch2_step1", 32'(dut.gen_ch[2].cnt), 32'hFF);
    tick();
`ifdef LBL_BLOCK_SATURATE_EN
    check("ch2_step2", 32'(dut.gen_ch[2].cnt), 32'hFF);
    tick();
    check("ch2_step3", 32'(dut.gen_ch[2].cnt), 32'hFF);
    check("ch2_sat",   32'(dut.gen_ch[2].upd.sat), 32'd1);
`else
    check("ch2_step2", 32'(dut.gen_ch[2].cnt), 32'h00);
    tick();
    check("ch2_step3", 32'(dut.gen_ch[2].cnt), 32'h01);
`endif
    en = '0;

    // Static scan of 10,20,30,40
    do_load(0, 10); do_load(1, 20); do_load(2, 30); do_load(3, 40);
    scan_start = 1'b1; tick(); scan_start = 1'b0;
    n = 0; seen = 1'b0;
    while (n < 10 && !seen) begin tick(); n++; if (scan_done) seen = 1'b1; end
    check("scan_latency", 32'(n), 32'd5);
    check("scan_sum_100", 32'(scan_sum), 32'd100);

    // Load ch3 while the scanner is at idx 1
    scan_start = 1'b1; tick(); scan_start = 1'b0;
    tick();
    load = 1'b1; load_ch = 2'd3; load_val = 8'd7;
    tick();
    load = 1'b0;
    n = 0; seen = 1'b0; last_ch3 = -1;
    while (n < 10 && !seen) begin
      tick(); n++;
      if (scan_valid && scan_ch == 2'd3) last_ch3 = int'(scan_val);
      if (scan_done) seen = 1'b1;
    end
    check("scan_ch3_7",  32'(last_ch3), 32'd7);
    check("scan_sum_67", 32'(scan_sum), 32'd67);

    // scan_start held high: restart only after DONE
    scan_start = 1'b1; dones = 0; t1 = 0; t2 = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (scan_done) begin dones++; if (dones == 1) t1 = t; else t2 = t; end
    end
    scan_start = 1'b0;
    check("held_done_count", 32'(dones), 32'd2);
    check("held_first_done", 32'(t1), 32'd6);
    check("held_second_done", 32'(t2), 32'd12);
    repeat (8) tick();

    // Random traffic
    for (int r = 0; r < 400; r++) begin
      en         = CH'($urandom);
      load       = ($urandom_range(0, 3) == 0);
      load_ch    = IDX_W'($urandom);
      load_val   = ($urandom_range(0, 3) == 0) ? W'(MAXV - $urandom_range(0, 1)) : W'($urandom);
      scan_start = ($urandom_range(0, 7) == 0);
      rst_n      = ($urandom_range(0, 63) != 0);
      tick();
    end
    rst_n = 1'b1; en = '0; load = 1'b0; scan_start = 1'b0;
    repeat (10) tick();

    // Reset while the scanner is about to visit idx 2
    scan_start = 1'b1; tick(); scan_start = 1'b0;
    tick(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    dones = 0;
    repeat (8) begin tick(); if (scan_done) dones++; end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_sum",     32'(scan_sum), 32'd0);
    check("abort_busy",    32'(scan_busy), 32'd0);

    // Out-of-range load_ch on the CH=5 instance
    load5 = 1'b1; load_val5 = 8'h55;
    for (int c = 5; c < 8; c++) begin load_ch5 = 3'(c); tick(); end
    load5 = 1'b0;
    check("oob_ch0", 32'(dut5.gen_ch[0].cnt), 32'd0);
    check("oob_ch1", 32'(dut5.gen_ch[1].cnt), 32'd0);
    check("oob_ch2", 32'(dut5.gen_ch[2].cnt), 32'd0);
    check("oob_ch3", 32'(dut5.gen_ch[3].cnt), 32'd0);
    check("oob_ch4", 32'(dut5.gen_ch[4].cnt), 32'd0);
    load5 = 1'b1; load_ch5 = 3'd4; load_val5 = 8'd9; tick(); load5 = 1'b0;
    check("inrange_ch4", 32'(dut5.gen_ch[4].cnt), 32'd9);
    check("inrange_ch0", 32'(c0v5), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
